// File: rtl/lsb_msg_extractor_if.sv
// ---------------------------------------------------------------------------
// lsb_msg_extractor_if
//   Bundles the pixel-word input stream, the message-byte output stream and
//   the extraction control/status lines of lsb_msg_extractor.
//
//   start        master->slave  1-cycle pulse: clear and begin extraction
//   pixel_data   master->slave  pixel word, byte i = pixel_data[8i+7:8i]
//   pixel_valid  master->slave  pixel_data valid
//   pixel_ready  slave->master  word accepted when valid & ready
//   msg_data     slave->master  extracted message byte
//   msg_valid    slave->master  msg_data valid
//   msg_ready    master->slave  sink accepts when valid & ready
//   delimiter    slave->master  1-cycle pulse on delimiter detection
//   done         slave->master  extraction finished and output drained
//   overflow     slave->master  stopped on byte limit without a delimiter
//   msg_len      slave->master  count of non-delimiter bytes emitted
//
//   The extractor's BYTES_PER_WORD / LEN_W must match the values used here.
// ---------------------------------------------------------------------------
interface lsb_msg_extractor_if #(
    parameter int BYTES_PER_WORD = 8,
    parameter int LEN_W          = 16
);
    logic                        start;
    logic [8*BYTES_PER_WORD-1:0] pixel_data;
    logic                        pixel_valid;
    logic                        pixel_ready;
    logic [7:0]                  msg_data;
    logic                        msg_valid;
    logic                        msg_ready;
    logic                        delimiter;
    logic                        done;
    logic                        overflow;
    logic [LEN_W-1:0]            msg_len;

    // Pixel source / message sink side.
    modport master (
        output start, pixel_data, pixel_valid, msg_ready,
        input  pixel_ready, msg_data, msg_valid, delimiter, done, overflow, msg_len
    );

    // Extractor side.
    modport slave (
        input  start, pixel_data, pixel_valid, msg_ready,
        output pixel_ready, msg_data, msg_valid, delimiter, done, overflow, msg_len
    );
endinterface

// File: rtl/lsb_msg_extractor.sv
// ---------------------------------------------------------------------------
// lsb_msg_extractor
//   LSB steganography extractor. Every accepted pixel word contributes the
//   low LSB_BITS of each of its bytes; those bits are packed LSB-first into
//   message bytes which are streamed out until the DELIM byte is found or
//   MAX_BYTES bytes have been emitted.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    lsb_msg_extractor_if.slave (pixel stream in, byte stream out,
//            start / delimiter / done / overflow / msg_len)
//
//   Data path: extracted vector e (BPW = BYTES_PER_WORD*LSB_BITS bits) is
//   OR-ed into the accumulator above the cnt pending bits. acc[0] is always
//   the oldest bit, so a byte pop is acc[7:0] followed by a shift right by 8.
//   Pushes only happen with cnt<8 and pops only with cnt>=8, which bounds the
//   accumulator at BPW+7 bits.
// ---------------------------------------------------------------------------

// Per-byte field extractor: the low LSB_BITS of one pixel byte.
module lsb_msg_lane #(
    parameter int LSB_BITS = 1
) (
    input  logic [LSB_BITS-1:0] lsbs_in,
    output logic [LSB_BITS-1:0] lsbs_out
);
    assign lsbs_out = lsbs_in;
endmodule

module lsb_msg_extractor #(
    parameter int         BYTES_PER_WORD = 8,
    parameter int         LSB_BITS       = 1,
    parameter logic [7:0] DELIM          = 8'h00,
    parameter int         MAX_BYTES      = 1024,
    parameter int         LEN_W          = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    lsb_msg_extractor_if.slave  bus
);
    localparam int BPW   = BYTES_PER_WORD * LSB_BITS;
    localparam int ACC_W = BPW + 7;
    localparam int CNT_W = $clog2(ACC_W + 1);

    localparam logic [CNT_W-1:0] CNT_BYTE = CNT_W'(8);
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(BPW);
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_BYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Output byte register: data is held while valid && !ready.
    typedef struct packed {
        logic [7:0] data;
        logic       valid;
    } msg_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    msg_t             msg_q;
    logic [LEN_W-1:0] len_q;
    logic             delim_q;
    logic             ovf_q;

    // ---------------- bit extraction ----------------
    logic [BYTES_PER_WORD-1:0][LSB_BITS-1:0] lane_bits;

    for (genvar i = 0; i < BYTES_PER_WORD; i++) begin : g_lane
        lsb_msg_lane #(.LSB_BITS(LSB_BITS)) u_lane (
            .lsbs_in  (bus.pixel_data[8*i +: LSB_BITS]),
            .lsbs_out (lane_bits[i])
        );
    end

    // New bits land directly above the bits still pending in acc.
    logic [ACC_W-1:0] ext_aligned;
    assign ext_aligned = ACC_W'(lane_bits) << cnt;

    // ---------------- handshake decode ----------------
    logic pixel_ready;
    logic push;
    logic pop;
    logic is_delim;

    assign pixel_ready = (state == RUN) && (cnt < CNT_BYTE);
    assign push        = bus.pixel_valid && pixel_ready;
    assign pop         = (state == RUN) && (cnt >= CNT_BYTE) &&
                         (!msg_q.valid || bus.msg_ready);
    assign is_delim    = (acc[7:0] == DELIM);

    // ---------------- state / data path ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            msg_q   <= '0;
            len_q   <= '0;
            delim_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            delim_q <= 1'b0;
            if (bus.start) begin
                // Restart from any state; a byte still waiting on the sink is dropped.
                state   <= RUN;
                acc     <= '0;
                cnt     <= '0;
                msg_q   <= '0;
                len_q   <= '0;
                ovf_q   <= 1'b0;
            end else begin
                if (msg_q.valid && bus.msg_ready)
                    msg_q.valid <= 1'b0;

                if (push) begin
                    acc <= acc | ext_aligned;
                    cnt <= cnt + CNT_WORD;
                end else if (pop) begin
                    if (is_delim) begin
                        // Delimiter is consumed, not emitted; trailing bits are dropped.
                        delim_q <= 1'b1;
                        state   <= DONE;
                        acc     <= '0;
                        cnt     <= '0;
                    end else begin
                        msg_q.data  <= acc[7:0];
                        msg_q.valid <= 1'b1;
                        len_q       <= len_q + LEN_W'(1);
                        if (len_q == LEN_LAST) begin
                            state <= DONE;
                            ovf_q <= 1'b1;
                            acc   <= '0;
                            cnt   <= '0;
                        end else begin
                            acc <= acc >> 8;
                            cnt <= cnt - CNT_BYTE;
                        end
                    end
                end
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.pixel_ready = pixel_ready;
    assign bus.msg_data    = msg_q.data;
    assign bus.msg_valid   = msg_q.valid;
    assign bus.delimiter   = delim_q;
    assign bus.overflow    = ovf_q;
    assign bus.msg_len     = len_q;
    // Finished only once the last emitted byte has been taken by the sink.
    assign bus.done        = (state == DONE) && !msg_q.valid;

endmodule
